// File: rtl/fsm_stim_if.sv
`default_nettype none
// ============================================================================
// Module   : fsm_stim_if
// Purpose  : Request/completion handshake between a requester and fsm_stim.
//            The requester offers a target state, fsm_stim signals when it
//            can take one and pulses done when the driven FSM has reached it.
// Signals  : req_valid   requester -> stimulator, request present
//            req_target  requester -> stimulator, requested target state
//            req_ready   stimulator -> requester, request can be accepted
//            done        stimulator -> requester, one-cycle completion pulse
// Revision : 1.0 - initial release
// ============================================================================
interface fsm_stim_if;
  logic       req_valid;
  logic [1:0] req_target;
  logic       req_ready;
  logic       done;

  modport master (
    output req_valid,
    output req_target,
    input  req_ready,
    input  done
  );

  modport slave (
    input  req_valid,
    input  req_target,
    output req_ready,
    output done
  );
endinterface
`default_nettype wire

// File: rtl/fsm_stim.sv
`default_nettype none
// ============================================================================
// Module   : fsm_stim
// Purpose  : Steers an external four-state FSM to a requested state by
//            emitting legal input symbols (or a reset pulse), one step per
//            cycle, while tracking the expected FSM state in shadow_state.
// Ports    : clk           rising-edge clock
//            reset         asynchronous active-high reset
//            req           fsm_stim_if.slave (req_valid, req_target,
//                          req_ready, done)
//            in_code       symbol fed to the driven FSM (00 when idle)
//            tgt_rst       one-cycle synchronous reset for the driven FSM
//            state_obs     state reported by the driven FSM
//            shadow_state  internal model of the driven FSM state
//            err           sticky mismatch flag
// Options  : FSM_STIM_CHECK_EN - when defined, state_obs is compared with
//            shadow_state in SETTLE and a mismatch sets err. When undefined,
//            err is tied low and state_obs is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module fsm_stim (
  input  wire logic       clk,
  input  wire logic       reset,
  fsm_stim_if.slave       req,
  output logic [1:0]      in_code,
  output logic            tgt_rst,
  input  wire logic [1:0] state_obs,
  output logic [1:0]      shadow_state,
  output logic            err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SETTLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t     state;
  logic [1:0] target;
  logic       ready_q;
  logic       done_q;

  assign req.req_ready = ready_q;
  assign req.done      = done_q;

  // Transition function of the driven FSM. Codes that are illegal in a
  // state are never emitted, so they simply hold the state here.
  function automatic logic [1:0] fsm_next(input logic [1:0] s, input logic [1:0] c);
    logic [1:0] n;
    n = s;
    case (s)
      2'd0: n = (c == 2'b01) ? 2'd1 : 2'd0;
      2'd1: n = (c == 2'b00) ? 2'd1 : c;
      2'd2: n = (c == 2'b01) ? 2'd1 : 2'd2;
      2'd3: n = (c == 2'b01) ? 2'd1 : 2'd3;
    endcase
    return n;
  endfunction

  // First move on the shortest legal path from s to t, as {tgt_rst, code}.
  // Every path to S2/S3 goes through S1, so planning one step at a time
  // from the updated shadow reproduces the full multi-step path.
  function automatic logic [2:0] first_step(input logic [1:0] s, input logic [1:0] t);
    logic [2:0] m;
    m = 3'b000;
    if (s != t) begin
      case (t)
        2'd0: m = 3'b100;
        2'd1: m = 3'b001;
        2'd2: m = (s == 2'd1) ? 3'b010 : 3'b001;
        2'd3: m = (s == 2'd1) ? 3'b011 : 3'b001;
      endcase
    end
    return m;
  endfunction

  logic [2:0] first_move;
  logic [1:0] shadow_next;
  logic [2:0] next_move;

  assign first_move  = first_step(shadow_state, req.req_target);
  assign shadow_next = tgt_rst ? 2'd0 : fsm_next(shadow_state, in_code);
  assign next_move   = first_step(shadow_next, target);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      target       <= 2'd0;
      shadow_state <= 2'd0;
      in_code      <= 2'b00;
      tgt_rst      <= 1'b0;
      done_q       <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ready_q <= 1'b1;
          done_q  <= 1'b0;
          if (req.req_valid && ready_q) begin
            target  <= req.req_target;
            ready_q <= 1'b0;
            if (req.req_target == shadow_state) begin
              state <= SETTLE;
            end else begin
              state              <= DRIVE;
              {tgt_rst, in_code} <= first_move;
            end
          end
        end
        DRIVE: begin
          shadow_state <= shadow_next;
          if (shadow_next == target) begin
            in_code <= 2'b00;
            tgt_rst <= 1'b0;
            state   <= SETTLE;
          end else begin
            {tgt_rst, in_code} <= next_move;
          end
        end
        SETTLE: begin
          done_q <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

`ifdef FSM_STIM_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err <= 1'b0;
    end else if (state == SETTLE && state_obs != shadow_state) begin
      err <= 1'b1;
    end
  end
`else
  logic unused_state_obs;
  assign unused_state_obs = ^state_obs;
  assign err              = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/fsm_stim.md
FSM_STIM -- requirements
Module: fsm_stim

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port req_valid, input, 1, a target-state request is present.
REQ-004 SHALL have port req_target, input, 2, requested state for the driven FSM: 00=S0, 01=S1, 10=S2, 11=S3.
REQ-005 SHALL have port req_ready, output, 1, block can accept a request.
REQ-006 SHALL have port in_code, output, 2, input symbol fed to the driven FSM.
REQ-007 SHALL have port tgt_rst, output, 1, one-cycle synchronous reset pulse for the driven FSM.
REQ-008 SHALL have port state_obs, input, 2, state reported by the driven FSM.
REQ-009 SHALL have port shadow_state, output, 2, internal model of the driven FSM state.
REQ-010 SHALL have port done, output, 1, one-cycle pulse when a request completes.
REQ-011 SHALL have port err, output, 1, sticky mismatch flag.

Function
REQ-012 SHALL model the driven FSM transition table exactly:
- S0: 00->S0, 01->S1
- S1: 00->S1, 01->S1, 10->S2, 11->S3
- S2: 00->S2, 01->S1, 10->S2
- S3: 00->S3, 01->S1, 11->S3
REQ-013 SHALL emit only codes that are legal in the current shadow_state, and SHALL emit 00 whenever it is not driving a step.
REQ-014 SHALL implement the states IDLE, DRIVE, SETTLE and DONE.
REQ-015 SHALL assert req_ready only in IDLE, and SHALL accept a request on a clk edge where req_valid=1 and req_ready=1.
REQ-016 SHALL latch req_target on acceptance and plan the step path from shadow_state:
- equal target: 0 steps
- target S1 from S0, S2 or S3: code 01
- target S2 from S0 or S3: codes 01, 10
- target S3 from S0 or S2: codes 01, 11
- target S2 from S1: code 10
- target S3 from S1: code 11
- target S0 from any non-S0 state: one tgt_rst pulse in place of codes
REQ-017 SHALL drive one step per cycle in DRIVE, updating shadow_state per REQ-012 (or to S0 on tgt_rst) at the end of that cycle.
REQ-018 SHALL skip DRIVE on a 0-step request (IDLE->SETTLE), so accept-to-done latency is (steps + 2) cycles.
REQ-019 SHALL spend exactly one cycle in SETTLE, then pulse done for one cycle in DONE, then return to IDLE.
REQ-020 SHALL ignore req_valid and hold req_target internally while not in IDLE.
REQ-021 SHALL never assert tgt_rst and a non-00 in_code in the same cycle.

Reset
REQ-022 SHALL, while reset is asserted (asynchronously):
- enter IDLE with shadow_state=00 and in_code=00
- drive tgt_rst=0, done=0, err=0 and req_ready=0
REQ-023 SHALL assert req_ready in the first cycle after reset deasserts.
REQ-024 SHALL abandon an in-progress request if reset is asserted mid-operation, with no done pulse for it.

Configuration
REQ-025 SHALL, with FSM_STIM_CHECK_EN defined, compare state_obs with shadow_state in SETTLE and set err=1 on mismatch (cleared only by reset).
REQ-026 SHALL, without FSM_STIM_CHECK_EN, tie err to 0 and ignore state_obs.

Verification
REQ-027 SHALL pass: after reset, request 10 -> in_code 01 then 10, shadow_state 01 then 10, done 4 cycles after acceptance.
REQ-028 SHALL pass: shadow 10, request 11 -> in_code 01, 11, shadow_state=11, err=0.
REQ-029 SHALL pass: shadow 11, request 00 -> single tgt_rst pulse with in_code=00, shadow_state=00, done 3 cycles after acceptance.
REQ-030 SHALL pass: shadow 01, request 01 -> no non-00 codes, done 2 cycles after acceptance.
REQ-031 SHALL pass: with check enabled, state_obs forced to 00 during SETTLE of a request 01 -> err=1 and stays 1 until reset.
REQ-032 SHALL pass: reset asserted during DRIVE -> outputs return to reset values immediately, no done pulse, req_ready=1 after release.
